// File: rtl/nfl_defs.sv
// Shared definitions for the nibble frame loader: FSM encodings and data width.
package nfl_defs;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 1 (idle-high line).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/nibble_frame_loader.sv
// Receives start/4-data/[parity]/stop frames on a strobed serial line and
// presents each good nibble with a one-cycle load pulse.
import nfl_defs::*;

module nibble_frame_loader #(
    parameter int PARITY_EN   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              load,
    output logic              busy,
    output logic              parity_err,
    output logic              framing_err
);

    logic              w_rx;
    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_shift;
    logic              r_err;
    logic [DATA_W-1:0] r_data_out;
    logic              r_load;
    logic              r_parity_err;
    logic              r_framing_err;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (w_rx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bit_en) begin
            case (r_state)
                IDLE:    if (!w_rx) w_next_state = DATA;
                DATA:    if (r_count == 2'd3) w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  w_next_state = STOP;
                STOP:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Frame datapath; everything here advances only on bit_en cycles except the load pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= 2'd0;
            r_shift       <= '0;
            r_err         <= 1'b0;
            r_data_out    <= '0;
            r_load        <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rx) begin
                            r_count       <= 2'd0;
                            r_err         <= 1'b0;
                            r_parity_err  <= 1'b0;
                            r_framing_err <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift[r_count] <= w_rx;
                        r_count          <= r_count + 2'd1;
                    end
                    PARITY: begin
                        r_err <= ^{r_shift, w_rx};
                    end
                    STOP: begin
                        if (!w_rx) r_framing_err <= 1'b1;
                        if (r_err) r_parity_err <= 1'b1;
                        if (w_rx && !r_err) begin
                            r_data_out <= r_shift;
                            r_load     <= 1'b1;
                        end
                    end
                    default: begin
                        r_count <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign data_out    = r_data_out;
    assign load        = r_load;
    assign busy        = (r_state != IDLE);
    assign parity_err  = r_parity_err;
    assign framing_err = r_framing_err;

endmodule

// File: tb/tb_nibble_frame_loader.sv
// Bench for nibble_frame_loader: parity and no-parity instances, table-driven frames
// with a load scoreboard, plus reset-abort, glitch and back-to-back sequences.
module tb_nibble_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, serial_in, bit_en;
    logic [3:0] data_out;
    logic       load, busy, parity_err, framing_err;

    logic       reset0, serial_in0, bit_en0;
    logic [3:0] data_out0;
    logic       load0, busy0, parity_err0, framing_err0;

    nibble_frame_loader #(.PARITY_EN(1), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .bit_en      (bit_en),
        .data_out    (data_out),
        .load        (load),
        .busy        (busy),
        .parity_err  (parity_err),
        .framing_err (framing_err)
    );

    nibble_frame_loader #(.PARITY_EN(0), .SYNC_STAGES(3)) dut0 (
        .clk         (clk),
        .reset       (reset0),
        .serial_in   (serial_in0),
        .bit_en      (bit_en0),
        .data_out    (data_out0),
        .load        (load0),
        .busy        (busy0),
        .parity_err  (parity_err0),
        .framing_err (framing_err0)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] sb_q[$];
    logic [3:0] sb0_q[$];
    logic [3:0] last_good = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side of the parity instance.
    logic       prev_load = 1'b0;
    logic [3:0] prev_dout = 4'h0;
    always @(negedge clk) begin
        if (load) begin
            check("load_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check("sb_data", data_out, sb_q.pop_front());
            check("load_single_cycle", prev_load, 0);
        end
        if (!reset && (data_out !== prev_dout)) check("dout_changes_only_with_load", load, 1);
        prev_load = load;
        prev_dout = data_out;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int load0_cnt = 0;
    int load0_cyc[2];
    always @(negedge clk) begin
        if (load0) begin
            check("load0_expected", (sb0_q.size() != 0), 1);
            if (sb0_q.size() != 0) check("sb0_data", data_out0, sb0_q.pop_front());
            if (load0_cnt < 2) load0_cyc[load0_cnt] = cyc;
            load0_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_en    = 1'b0;
        repeat (3) @(negedge clk);
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] data, input logic flip, input logic stop,
                              input logic exp_load, input logic exp_perr, input logic exp_ferr,
                              input string name);
        logic p;
        p = (^data) ^ flip;
        if (exp_load) sb_q.push_back(data);
        send_bit(1'b0);
        check({name, "_busy_after_start"}, busy, 1);
        for (int i = 0; i < 4; i++) send_bit(data[i]);
        send_bit(p);
        send_bit(stop);
        check({name, "_load"}, load, exp_load);
        if (exp_load) last_good = data;
        @(negedge clk);
        serial_in = 1'b1;
        check({name, "_load_low"}, load, 0);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_parity_err"}, parity_err, exp_perr);
        check({name, "_framing_err"}, framing_err, exp_ferr);
        check({name, "_data_out"}, data_out, last_good);
    endtask

    typedef struct {
        logic [3:0] data;
        logic       flip;
        logic       stop;
        logic       exp_load;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nib;

        tbl[0] = '{4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{4'hD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; serial_in = 1'b1; bit_en = 1'b0;
        reset0 = 1'b1; serial_in0 = 1'b1; bit_en0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {data_out, load, busy, parity_err, framing_err}, 8'h00);
        check("reset_state0", {data_out0, load0, busy0, parity_err0, framing_err0}, 8'h00);
        reset = 1'b0; reset0 = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].flip, tbl[i].stop,
                       tbl[i].exp_load, tbl[i].exp_perr, tbl[i].exp_ferr,
                       $sformatf("row%0d", i));
            repeat (2) @(negedge clk);
        end

        // Reset after the second data bit of 4'h5 abandons the frame.
        check("pre_reset_dout", data_out, 4'hD);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("abort_busy_before_reset", busy, 1);
        #2 reset = 1'b1;
        #1 check("reset_immediate", {data_out, load, busy, parity_err, framing_err}, 8'h00);
        @(negedge clk);
        serial_in = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        last_good = 4'h0;
        @(negedge clk);
        check("post_reset_idle", busy, 0);
        send_frame(4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "after_reset");
        repeat (2) @(negedge clk);

        // One-cycle low glitch while bit_en stays low must not start a frame.
        serial_in = 1'b0;
        @(negedge clk);
        serial_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("glitch_busy", busy, 0);
        end
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            check("glitch_idle_strobe_busy", busy, 0);
        end
        check("glitch_dout_held", data_out, 4'h5);

        // Back-to-back frames with bit_en held high on the no-parity instance.
        sb0_q.push_back(4'h3);
        sb0_q.push_back(4'hC);
        bit_en0 = 1'b1;
        repeat (5) @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            nib = (f == 0) ? 4'h3 : 4'hC;
            serial_in0 = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                serial_in0 = nib[i];
                @(negedge clk);
            end
            serial_in0 = 1'b1;
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        bit_en0 = 1'b0;
        check("b2b_load_count", load0_cnt, 2);
        check("b2b_load_spacing", load0_cyc[1] - load0_cyc[0], 6);
        check("b2b_final_dout", data_out0, 4'hC);
        check("b2b_idle_flags", {busy0, parity_err0, framing_err0}, 3'b000);

        check("sb_drained", sb_q.size(), 0);
        check("sb0_drained", sb0_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_frame_loader.md
NIBBLE_FRAME_LOADER -- requirements
Module: nibble_frame_loader

Interface
REQ-001 The block SHALL have parameter PARITY_EN, default 1: 1 = even-parity bit present in the frame; 0 = no parity bit.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, range 2..4: number of synchronizer flops on serial_in.
REQ-003 Port clk  input  1  rising-edge system clock.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port serial_in  input  1  asynchronous serial line; idles high.
REQ-006 Port bit_en  input  1  bit-period strobe, one clk cycle wide; the FSM samples and advances only on cycles where it is 1.
REQ-007 Port data_out  output  4  last accepted nibble; drives the downstream register's In.
REQ-008 Port load  output  1  one-cycle pulse marking data_out as new; drives the downstream register's load.
REQ-009 Port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-010 Port parity_err  output  1  sticky flag: last frame failed the parity check.
REQ-011 Port framing_err  output  1  sticky flag: last frame had a stop bit of 0.

Function
REQ-012 Frame format SHALL be: start (0), 4 data bits LSB first, parity bit (only when PARITY_EN=1), stop (1).
REQ-013 serial_in SHALL pass through SYNC_STAGES flops before any use; "rx" below means the synchronized value.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY and STOP; all transitions SHALL occur only on bit_en=1 cycles.
REQ-015 IDLE: if rx=0 at a bit_en cycle, go to DATA, clear the bit count, and clear parity_err and framing_err; otherwise stay in IDLE.
REQ-016 DATA: each bit_en writes rx into shift bit [count] and increments count; after count=3 go to PARITY if PARITY_EN=1, else go to STOP.
REQ-017 PARITY: at bit_en, compute err = XOR(shift[3:0], rx); go to STOP.
REQ-018 STOP, when rx=1 and err=0: data_out <= shift, load=1, go to IDLE.
REQ-019 STOP, when rx=0: framing_err=1, no load, data_out unchanged, go to IDLE.
REQ-020 STOP, when rx=1 and err=1: parity_err=1, no load, data_out unchanged, go to IDLE.
REQ-021 STOP, when both rx=0 and err=1: both error flags SHALL set.
REQ-022 load SHALL be registered, high exactly one clk cycle, in the cycle after the bit_en cycle that sampled the stop bit.
REQ-023 data_out SHALL change only in the same cycle that load rises, and SHALL hold otherwise.
REQ-024 bit_en held high on consecutive cycles SHALL be legal; each such cycle counts as one bit.
REQ-025 A start bit SHALL be accepted at the bit_en immediately after the stop bit, with no idle gap required.
REQ-026 The FSM SHALL NOT change state, count or shift contents on cycles where bit_en=0.

Reset
REQ-027 On reset=1, immediately: state=IDLE, count=0, shift=0, data_out=4'b0, load=0, busy=0, parity_err=0, framing_err=0, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abandon the frame; the next frame starts only at a fresh start bit after reset deasserts.

Structure
REQ-029 State encodings (2-bit) and the data width constant (4) SHALL live in a shared include/package file, nfl_defs.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_ff (parameter STAGES, reset value 1), reusable elsewhere.
REQ-031 All logic SHALL be single clock domain (clk); the synchronizer is the only CDC point.

Verification
REQ-032 PARITY_EN=1, frame 0,1,1,0,1,p=1,1 on bit_en every 4 clks -> data_out=4'hB, single-cycle load, both errors 0.
REQ-033 Same frame with p=0 -> parity_err=1, no load, data_out keeps its previous value; the next good frame clears parity_err.
REQ-034 Frame 0,0,0,0,1,p=1,stop=0 -> framing_err=1, no load, FSM back in IDLE (busy=0).
REQ-035 reset pulsed after the 2nd data bit -> all outputs 0 at once; the following complete frame with data 4'h5 gives data_out=4'h5 with load.
REQ-036 PARITY_EN=0, back-to-back frames 4'h3 then 4'hC with bit_en held high continuously -> two load pulses exactly 6 clks apart, carrying the correct values.
REQ-037 serial_in glitch to 0 on a cycle with bit_en=0 -> no start accepted and busy stays 0.
